// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcode/funct constants, instruction classes and encode helpers
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  typedef enum logic [1:0] {CLS_R, CLS_LW, CLS_SW, CLS_BEQ} instr_class_e;
  function automatic logic funct_legal(logic [5:0] funct);
    return funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  endfunction
  function automatic logic [5:0] class_opcode(instr_class_e cls);
    return cls == CLS_R ? OP_RTYPE : cls == CLS_LW ? OP_LW : cls == CLS_SW ? OP_SW : OP_BEQ;
  endfunction
  // I-type words reuse the low 16 bits for the immediate, so rd/shamt/funct are dropped
  function automatic logic [31:0] encode(instr_class_e cls, logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] rd, logic [4:0] shamt, logic [5:0] funct,
                                         logic [15:0] imm);
    return cls == CLS_R ? {OP_RTYPE, rs, rt, rd, shamt, funct} : {class_opcode(cls), rs, rt, imm};
  endfunction
endpackage

// File: rtl/mips_instr_encoder_if.sv
// mips_instr_encoder_if: request/stream/status bundle between producer and encoder
interface mips_instr_encoder_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_class;
  logic [4:0]       in_rs;
  logic [4:0]       in_rt;
  logic [4:0]       in_rd;
  logic [4:0]       in_shamt;
  logic [5:0]       in_funct;
  logic [15:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             err_pulse;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] drop_count;
  modport master (
    output in_valid, in_class, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, err_pulse, enc_count, drop_count
  );
  modport slave (
    input  in_valid, in_class, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, out_ready,
    output in_ready, out_valid, out_instr, err_pulse, enc_count, drop_count
  );
endinterface

// File: rtl/mips_instr_fifo.sv
// mips_instr_fifo: synchronous first-word-fall-through FIFO
module mips_instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  // storage and pointers; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= (do_push && !do_pop) ? count + 1'b1 : (do_pop && !do_push) ? count - 1'b1 : count;
    end
  end
endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: assembles MIPS words from field descriptions and streams them through a FIFO
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  mips_instr_encoder_if.slave bus
);
  instr_class_e            cls;
  logic                    legal;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [31:0]             word;
  logic [$clog2(DEPTH):0]  count;
  // decode the request class and build the candidate word
  always_comb begin
    cls   = instr_class_e'(bus.in_class);
    legal = cls != CLS_R || funct_legal(bus.in_funct);
    word  = encode(cls, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct, bus.in_imm);
  end
  assign bus.in_ready  = rst_n && !full;
  assign bus.out_valid = count != '0;
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = accept && legal;
  assign pop           = bus.out_ready && !empty;
  mips_instr_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (word),
    .dout  (bus.out_instr),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // drop pulse and saturating accept/drop counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.err_pulse  <= 1'b0;
      bus.enc_count  <= '0;
      bus.drop_count <= '0;
    end else begin
      bus.err_pulse  <= accept && !legal;
      bus.enc_count  <= (push && !(&bus.enc_count)) ? bus.enc_count + 1'b1 : bus.enc_count;
      bus.drop_count <= (accept && !legal && !(&bus.drop_count)) ? bus.drop_count + 1'b1 : bus.drop_count;
    end
  end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: directed plus randomized checks of the encoder against a queue-based reference
module tb_mips_instr_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mips_instr_encoder_if #(.CNT_W(16)) bus ();
  mips_instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [31:0] q[$];
  int enc_m = 0;
  int drop_m = 0;
  bit err_m = 1'b0;
  int checks = 0;
  int failures = 0;
  function automatic bit ref_legal();
    return bus.in_class != 2'd0 || bus.in_funct inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
  endfunction
  function automatic logic [31:0] ref_word();
    longint op, low;
    op  = bus.in_class == 2'd0 ? 0 : bus.in_class == 2'd1 ? 35 : bus.in_class == 2'd2 ? 43 : 4;
    low = bus.in_class == 2'd0 ? longint'(bus.in_rd) * 2048 + longint'(bus.in_shamt) * 64 + longint'(bus.in_funct)
                               : longint'(bus.in_imm);
    return 32'(op * 67108864 + longint'(bus.in_rs) * 2097152 + longint'(bus.in_rt) * 65536 + low);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("in_ready", 32'(bus.in_ready), 32'(rst_n && q.size() < 4));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("out_instr", bus.out_instr, q[0]);
    chk("err_pulse", 32'(bus.err_pulse), 32'(err_m));
    chk("enc_count", 32'(bus.enc_count), 32'(enc_m));
    chk("drop_count", 32'(bus.drop_count), 32'(drop_m));
  endtask
  task automatic tick();
    bit acc, pp, lg;
    logic [31:0] w;
    acc = rst_n && bus.in_valid && q.size() < 4;
    pp  = rst_n && q.size() != 0 && bus.out_ready;
    lg  = ref_legal();
    w   = ref_word();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      enc_m = 0;
      drop_m = 0;
      err_m = 1'b0;
    end else begin
      if (pp) void'(q.pop_front());
      err_m = acc && !lg;
      if (acc && lg) begin
        q.push_back(w);
        enc_m = enc_m < 65535 ? enc_m + 1 : enc_m;
      end
      if (acc && !lg) drop_m = drop_m < 65535 ? drop_m + 1 : drop_m;
    end
    check_all();
  endtask
  task automatic req(input logic [1:0] cls, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm);
    bus.in_valid = 1'b1;
    bus.in_class = cls;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_shamt = sh;
    bus.in_funct = fn;
    bus.in_imm   = imm;
  endtask
  initial begin
    logic [5:0] legal_f [5];
    legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    bus.out_ready = 1'b0;
    req(2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0);
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("rst_instr", bus.out_instr, 32'h0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    req(2'd0, 5'd10, 5'd11, 5'd9, 5'd0, 6'h20, 16'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("add_word", bus.out_instr, 32'h014B4820);
    chk("add_enc", 32'(bus.enc_count), 32'd1);
    tick();
    req(2'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4);
    tick();
    chk("lw_word", bus.out_instr, 32'h8D280004);
    req(2'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4);
    tick();
    chk("sw_word", bus.out_instr, 32'hAD280004);
    req(2'd3, 5'd9, 5'd10, 5'd0, 5'd0, 6'd0, 16'd2);
    tick();
    chk("beq_word", bus.out_instr, 32'h112A0002);
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(2'd1, 5'(i), 5'(i + 1), 5'd0, 5'd0, 6'd0, 16'(i * 8));
      tick();
    end
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    req(2'd3, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h5555);
    tick();
    bus.out_ready = 1'b1;
    tick();
    chk("full_pop_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("drain_empty", 32'(bus.out_valid), 32'd0);
    req(2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h08, 16'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("drop_err", 32'(bus.err_pulse), 32'd1);
    chk("drop_outv", 32'(bus.out_valid), 32'd0);
    tick();
    chk("drop_err_clr", 32'(bus.err_pulse), 32'd0);
    chk("drop_cnt", 32'(bus.drop_count), 32'd1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(2'd0, 5'(i), 5'd7, 5'd8, 5'(i), 6'h22, 16'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    req(2'd2, 5'd31, 5'd30, 5'd0, 5'd0, 6'd0, 16'hBEEF);
    tick();
    chk("pp_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_enc", 32'(bus.enc_count), 32'd0);
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      rst_n = $urandom_range(63) != 0;
      req(2'($urandom_range(3)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          $urandom_range(3) != 0 ? legal_f[$urandom_range(4)] : 6'($urandom), 16'($urandom));
      bus.in_valid  = $urandom_range(2) != 0;
      bus.out_ready = $urandom_range(2) != 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Streaming MIPS instruction encoder: takes a field-level instruction description (class, register numbers, shamt/funct, immediate) and assembles the 32-bit instruction word.
- It is the opposite direction of mips_decoder. Encoded words are buffered in a small FIFO and streamed out on a valid/ready interface.
- Unsupported R-type funct codes are dropped and counted.
- Used as the stimulus/ROM-fill front end that feeds mips_decoder and, later, the instruction memory loader.

Parameters:
DEPTH, 4, output FIFO depth in entries (power of 2, >=2)
CNT_W, 16, width of accepted/dropped counters

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  request carries a valid instruction description
in_ready  output  1  encoder can accept a request this cycle
in_class  input  2  00=R-type, 01=LW, 10=SW, 11=BEQ
in_rs  input  5  source register rs
in_rt  input  5  register rt
in_rd  input  5  destination rd (R-type only)
in_shamt  input  5  shift amount (R-type only)
in_funct  input  6  function code (R-type only)
in_imm  input  16  offset/immediate (I-type only)
out_valid  output  1  out_instr holds a valid word
out_ready  input  1  consumer accepts word
out_instr  output  32  encoded instruction word
err_pulse  output  1  one-cycle pulse when a request is dropped
enc_count  output  CNT_W  number of words pushed into the FIFO
drop_count  output  CNT_W  number of dropped requests

Behaviour:
- Reset (rst_n=0 at a clk edge): FIFO emptied (pointers and occupancy = 0), out_valid=0, out_instr=0, err_pulse=0, enc_count=0, drop_count=0. in_ready=0 while rst_n=0.
- Reset asserted mid-stream discards all buffered words. No partial output is permitted.
- in_ready = rst_n && (occupancy < DEPTH). It depends only on registered state, never combinationally on out_ready.
- Accept: in_valid && in_ready at a clk edge.
- Encoding (combinational on inputs, registered on push):
  - R: {6'b000000, rs, rt, rd, shamt, funct}
  - LW: {6'b100011, rs, rt, imm}
  - SW: {6'b101011, rs, rt, imm}
  - BEQ: {6'b000100, rs, rt, imm}
  - I-type ignores rd/shamt/funct.
- Legal R-type funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
- An accepted R-type with any other funct:
  - Is not pushed.
  - err_pulse=1 on the following cycle only.
  - drop_count increments.
- Accepted legal request: word is pushed; enc_count increments.
- Latency: a word accepted at edge N is visible at out_valid/out_instr after edge N, i.e. in cycle N+1. There is no combinational in->out path.
- Output: out_valid = (occupancy != 0); out_instr = FIFO head (first-word-fall-through). The head pops when out_valid && out_ready.
- Simultaneous push and pop: occupancy is unchanged and order is preserved. Allowed whenever in_ready=1, including occupancy=DEPTH-1.
- Full (occupancy=DEPTH): in_ready=0 even if out_ready=1 that cycle. A pop frees the slot for the next cycle.
- Empty: out_valid=0 and out_instr holds its last value (don't care). A pop request with out_valid=0 is ignored.
- Pointers wrap modulo DEPTH. Occupancy counter is $clog2(DEPTH)+1 bits.
- enc_count and drop_count saturate at all-ones; they do not wrap.
- out_instr stays stable while out_valid=1 && out_ready=0.

Decomposition:
- Package mips_pkg holds:
  - opcode constants OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT
  - 2-bit instr_class enum (CLS_R, CLS_LW, CLS_SW, CLS_BEQ)
- mips_decoder is to be migrated to the same package.
- One sub-module: mips_instr_fifo, a synchronous FWFT FIFO with parameters WIDTH and DEPTH and ports push/pop/full/empty/count. The encoder instantiates it with WIDTH=32.

Test Plan:
- Reset, then R-type add: rs=10, rt=11, rd=9, shamt=0, funct=0x20, out_ready=1 -> out_instr=0x014B4820 one cycle after accept; enc_count=1.
- LW rs=9, rt=8, imm=4, then SW with same fields, then BEQ rs=9, rt=10, imm=2, back-to-back -> outputs 0x8D280004, 0xAD280004, 0x112A0002 in order on consecutive cycles. Feed each word to mips_decoder and check it yields the expected R/LW/SW/BEQ control signals.
- out_ready=0, send 5 legal requests with DEPTH=4 -> in_ready falls after the 4th accept. Raise out_ready -> 4 words drain in order and the 5th is accepted.
- R-type with funct=0x08 -> no output; err_pulse high for exactly 1 cycle; drop_count=1; enc_count unchanged.
- At occupancy=3, push and pop in the same cycle -> occupancy stays 3 and order is intact. Assert rst_n=0 with 3 words buffered -> out_valid=0 and counters=0 next cycle.
